// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller: feeds each word LSB-first to an external Mealy
// detector and counts its hits. Define SEQ_SCAN_FLUSH_EN to clear the detector before every word.
module seq_scan_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             det_bit,
    output logic             det_clr,
    input  logic             det_out,
    output logic [CNT_W-1:0] hit_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] HIT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef SEQ_SCAN_FLUSH_EN
        FLUSH  = 2'd1,
`endif
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [IDX_W-1:0]   idx;

    // Scan sequencer; det_bit is registered one step ahead so it always tracks sreg[0] in SHIFT.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= IDLE;
            sreg       <= '0;
            idx        <= '0;
            hit_count  <= '0;
            word_ready <= 1'b1;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            det_bit    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (word_valid) begin
                        sreg       <= word_in;
                        idx        <= '0;
                        hit_count  <= '0;
                        word_ready <= 1'b0;
                        busy       <= 1'b1;
`ifdef SEQ_SCAN_FLUSH_EN
                        state      <= FLUSH;
                        det_bit    <= 1'b0;
`else
                        state      <= SHIFT;
                        det_bit    <= word_in[0];
`endif
                    end
                end
`ifdef SEQ_SCAN_FLUSH_EN
                FLUSH: begin
                    state   <= SHIFT;
                    det_bit <= sreg[0];
                end
`endif
                SHIFT: begin
                    if (det_out && (hit_count != HIT_MAX)) begin
                        hit_count <= hit_count + CNT_W'(1);
                    end
                    sreg <= sreg >> 1;
                    if (idx == IDX_LAST) begin
                        state     <= REPORT;
                        det_bit   <= 1'b0;
                        res_valid <= 1'b1;
                    end else begin
                        idx     <= idx + IDX_W'(1);
                        det_bit <= sreg[1];
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        state      <= IDLE;
                        res_valid  <= 1'b0;
                        busy       <= 1'b0;
                        word_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    res_valid  <= 1'b0;
                    busy       <= 1'b0;
                    word_ready <= 1'b1;
                    det_bit    <= 1'b0;
                end
            endcase
        end
    end

    // Detector clear follows block reset so a reset also clears the detector.
`ifdef SEQ_SCAN_FLUSH_EN
    assign det_clr = clr & (state != FLUSH);
`else
    assign det_clr = clr;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl with a parity-style Mealy detector model;
// expectations follow SEQ_SCAN_FLUSH_EN when defined.
module tb_seq_scan_ctrl;

    localparam int unsigned WIDTH = 8;
`ifdef SEQ_SCAN_FLUSH_EN
    localparam int LAT      = 9;
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam int LAT      = 8;
    localparam bit FLUSH_EN = 1'b0;
`endif
    localparam int FIRST = FLUSH_EN ? 2 : 1;

    logic             clk;
    logic             clr;
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             det_bit;
    logic             det_clr;
    logic             det_out;
    logic [3:0]       hit_count;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    logic             sat_word_ready;
    logic             sat_det_bit;
    logic             sat_det_clr;
    logic [1:0]       sat_hit_count;
    logic             sat_res_valid;
    logic             sat_busy;

    seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) u_dut (
        .clk        (clk),
        .clr        (clr),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .det_bit    (det_bit),
        .det_clr    (det_clr),
        .det_out    (det_out),
        .hit_count  (hit_count),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    // Second instance with a 2-bit counter and the detector stuck high, to exercise saturation.
    seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) u_sat (
        .clk        (clk),
        .clr        (clr),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (sat_word_ready),
        .det_bit    (sat_det_bit),
        .det_clr    (sat_det_clr),
        .det_out    (1'b1),
        .hit_count  (sat_hit_count),
        .res_valid  (sat_res_valid),
        .res_ready  (res_ready),
        .busy       (sat_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector: mode 0 echo, 1 stuck-0, 2 stuck-1, 3 "even-numbered one since clear".
    int   det_mode;
    logic par;
    always @(posedge clk) begin
        if (!det_clr) par <= 1'b0;
        else if (det_bit) par <= ~par;
    end
    assign det_out = (det_mode == 0) ? det_bit :
                     (det_mode == 1) ? 1'b0 :
                     (det_mode == 2) ? 1'b1 : (det_bit & par);

    int flush_lows = 0;
    always @(negedge clk) begin
        if (clr && !det_clr) flush_lows <= flush_lows + 1;
    end

    int         n_chk  = 0;
    int         n_pass = 0;
    int         exp_q[$];
    logic [7:0] word_q[$];
    int         last_exp;
    bit         m_par;
    int         n_acc;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Present a word and push its expected hit count.
    task automatic start_word(input logic [7:0] w);
        int c;
        c = 0;
        if (FLUSH_EN) m_par = 1'b0;
        for (int i = 0; i < 8; i++) begin
            case (det_mode)
                0:       if (w[i]) c++;
                1:       c = c;
                2:       c++;
                default: if (w[i] && m_par) c++;
            endcase
            if (w[i]) m_par = ~m_par;
        end
        exp_q.push_back((c > 15) ? 15 : c);
        word_q.push_back(w);
        word_in    = w;
        word_valid = 1'b1;
    endtask

    // Wait for acceptance and the result, checking latency, serial bits and count.
    task automatic run_word(input int exp_acc);
        int         n;
        int         k;
        int         b;
        logic [7:0] bits;
        logic [7:0] w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        chk("accept_cycle", n, exp_acc);
        word_valid = 1'b0;
        n_acc++;
        chk("det_clr_after_accept", int'(det_clr), FLUSH_EN ? 0 : 1);
        bits = '0;
        b    = 0;
        k    = 1;
        while (!res_valid && k < 30) begin
            if (FLUSH_EN && k == 1) chk("flush_det_bit", int'(det_bit), 0);
            if (k >= FIRST && b < 8) begin
                bits[b] = det_bit;
                b++;
            end
            @(negedge clk);
            k++;
        end
        chk("latency", k - 1, LAT);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            last_exp = exp_q.pop_front();
            w        = word_q.pop_front();
            chk("hit_count", int'(hit_count), last_exp);
            chk("serial_bits", int'(bits), int'(w));
        end
        chk("sat_hit_count", int'(sat_hit_count), 3);
        chk("sat_res_valid", int'(sat_res_valid), 1);
        chk("report_det_bit", int'(det_bit), 0);
        chk("report_word_ready", int'(word_ready), 0);
    endtask

    task automatic do_word(input int mode, input logic [7:0] w);
        det_mode = mode;
        start_word(w);
        run_word(1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        clr        = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        res_ready  = 1'b1;
        det_mode   = 0;
        m_par      = 1'b0;
        n_acc      = 0;
        last_exp   = 0;
        repeat (2) @(negedge clk);
        chk("rst_word_ready", int'(word_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_det_bit", int'(det_bit), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_det_clr", int'(det_clr), 0);
        chk("rst_sat_det_clr", int'(sat_det_clr), 0);
        clr = 1'b1;
        @(negedge clk);

        do_word(0, 8'hB5);
        do_word(1, 8'hFF);
        do_word(2, 8'h00);
        do_word(3, 8'hB5);
        do_word(3, 8'h07);
        do_word(3, 8'h01);

        // Result held off for five cycles; a pending word must not be taken.
        res_ready = 1'b0;
        det_mode  = 0;
        start_word(8'h0F);
        run_word(1);
        word_in    = 8'h3C;
        word_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_hit_count", int'(hit_count), last_exp);
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_word_ready", int'(word_ready), 0);
        end
        word_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        chk("release_idle_ready", int'(word_ready), 1);
        chk("release_res_valid", int'(res_valid), 0);
        @(negedge clk);
        chk("release_not_taken", int'(busy), 0);

        // Abort on the fourth SHIFT cycle.
        det_mode   = 0;
        word_in    = 8'hFF;
        word_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        chk("abort_accept", n, 1);
        word_valid = 1'b0;
        n_acc++;
        repeat (FIRST + 2) @(negedge clk);
        chk("abort_shift_bit", int'(det_bit), 1);
        clr = 1'b0;
        #1;
        chk("abort_det_clr", int'(det_clr), 0);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_word_ready", int'(word_ready), 1);
        chk("abort_hit_count", int'(hit_count), 0);
        clr   = 1'b1;
        m_par = 1'b0;
        @(negedge clk);
        chk("abort_no_result", int'(res_valid), 0);
        do_word(0, 8'hB5);

        // Back-to-back: next word waiting while the previous result transfers.
        det_mode = 3;
        start_word(8'h5A);
        run_word(1);
        start_word(8'h33);
        run_word(2);
        start_word(8'hC9);
        run_word(2);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_word((i % 2 == 0) ? 3 : 0, 8'($urandom));
        end

        chk("det_clr_low_cycles", flush_lows, FLUSH_EN ? n_acc : 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bits per word, serialized to the detector; legal range 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 4: hit counter width; legal when 2^CNT_W-1 >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-low (sampled on rising clk; 0 = reset).
REQ-005 The block SHALL have port word_in, input, WIDTH bits: word to scan, LSB sent first.
REQ-006 The block SHALL have port word_valid, input, 1 bit: word_in is valid.
REQ-007 The block SHALL have port word_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port det_bit, output, 1 bit: serial bit driven to the external Mealy detector's input.
REQ-009 The block SHALL have port det_clr, output, 1 bit: active-low synchronous clear driven to the detector.
REQ-010 The block SHALL have port det_out, input, 1 bit: detector Mealy output (combinational on det_bit and detector state).
REQ-011 The block SHALL have port hit_count, output, CNT_W bits: detections counted for the last word.
REQ-012 The block SHALL have port res_valid, output, 1 bit: hit_count holds a result.
REQ-013 The block SHALL have port res_ready, input, 1 bit: consumer takes the result.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, FLUSH (macro only), SHIFT and REPORT.
REQ-016 IDLE: word_ready=1; on word_valid=1, capture word_in into the shift register, zero the bit index and hit_count, then go to FLUSH (macro) or SHIFT.
REQ-017 FLUSH: det_clr=0 for exactly one cycle, then go to SHIFT.
REQ-018 SHIFT: det_bit = shift register bit 0; each cycle, if det_out=1, hit_count increments, saturating at 2^CNT_W-1.
REQ-019 SHIFT: the shift register shifts right each cycle; after WIDTH cycles (index = WIDTH-1) go to REPORT.
REQ-020 REPORT: res_valid=1 and hit_count held stable until res_ready=1, then go to IDLE in the next cycle.
REQ-021 word_ready SHALL be 0 outside IDLE; word_valid outside IDLE is ignored and the word is not consumed.
REQ-022 det_bit SHALL be 0 outside SHIFT.
REQ-023 det_clr SHALL equal clr AND NOT (state==FLUSH), so a block reset also clears the detector.
REQ-024 Latency SHALL be WIDTH+1 cycles with the macro, WIDTH without, from the accept edge to res_valid=1; throughput is one word per WIDTH+2 (+1 with macro) cycles with res_ready held at 1.
REQ-025 res_valid and res_ready both high in REPORT SHALL complete the transfer; word_ready rises the following cycle.

Reset
REQ-026 While clr=0 at a rising edge: state <= IDLE, hit_count <= 0, shift register <= 0, index <= 0.
REQ-027 Outputs after reset SHALL be: res_valid=0, busy=0, word_ready=1, det_bit=0.
REQ-028 Reset in any state, including mid-SHIFT or REPORT, SHALL abort the word and drop the result.

Configuration
REQ-029 SEQ_SCAN_FLUSH_EN defined: the FLUSH state exists and the detector is cleared before every word, so words are scanned independently.
REQ-030 SEQ_SCAN_FLUSH_EN undefined: FLUSH is removed, det_clr = clr, and detector state carries across word boundaries; latency reduces by 1.

Verification
REQ-031 With det_out tied to det_bit, WIDTH=8, word 0xB5: hit_count=5 and res_valid asserts 9 cycles after accept (macro) or 8 cycles (no macro).
REQ-032 With det_out=0 and word 0xFF: hit_count=0; with det_out=1, CNT_W=2, word 0x00: hit_count saturates at 3.
REQ-033 Hold res_ready=0 for 5 cycles in REPORT: hit_count stays stable, res_valid=1, word_ready=0, and a new word_valid is not accepted.
REQ-034 With the macro: det_clr=0 exactly one cycle, the cycle after accept; without the macro: det_clr is never 0 while clr=1.
REQ-035 Assert clr=0 on the 4th SHIFT cycle: next cycle IDLE, res_valid=0, busy=0, det_clr=0 during reset, and the next word scans normally.
REQ-036 Back-to-back words with res_ready=1: the second word is accepted exactly 1 cycle after the first result transfers.
